score_bcd_sequencer: RTL and testbench

Multi-cycle binary-to-decimal converter that turns the 10-bit game score into three BCD digits (hundreds, tens, ones) for the seven-segment score overlay. It samples the score once per video frame on a frame-start strobe, runs an iterative shift-and-add-3 conversion, and commits all three digits at once. Digits stay stable while a frame is being drawn, and the design needs no combinational dividers. It sits between the game-state logic and the per-digit segment renderers in the VGA pipeline.

---
 rtl/vga_params.sv | 14 +
 rtl/bcd_add3.sv | 9 +
 rtl/score_bcd_sequencer.sv | 111 +++++++++++
 tb/tb_score_bcd_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_params.sv
// Shared VGA-pipeline parameters and the score sequencer state encoding.
package vga_params;

  localparam int unsigned SCORE_W   = 10;
  localparam int unsigned SCORE_MAX = 999;
  localparam int unsigned BCD_W     = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } score_seq_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to a BCD nibble holding 5 or more.
module bcd_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib_c
);

  assign o_nib_c = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/score_bcd_sequencer.sv
// Converts the clamped binary score to three BCD digits once per frame using an
// iterative shift-and-add-3 loop; all digits commit together on one edge.
module score_bcd_sequencer
  import vga_params::*;
#(
  parameter int unsigned W       = SCORE_W,
  parameter int unsigned SAT_MAX = SCORE_MAX
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] score,
  input  logic         frame_start,
  output logic [3:0]   huns,
  output logic [3:0]   tens,
  output logic [3:0]   ones,
  output logic         digits_valid,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

  score_seq_state_t   r_state;
  score_seq_state_t   w_state_nxt;
  logic [W-1:0]       r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pending;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic [W-1:0]       w_score_sat;
  logic               w_capture;
  logic               w_shift;
  logic               w_commit;

  assign w_score_sat = (score > W'(SAT_MAX)) ? W'(SAT_MAX) : score;

  bcd_add3 u_add3_ones (.i_nib(r_bcd[3:0]),  .o_nib_c(w_bcd_adj[3:0]));
  bcd_add3 u_add3_tens (.i_nib(r_bcd[7:4]),  .o_nib_c(w_bcd_adj[7:4]));
  bcd_add3 u_add3_huns (.i_nib(r_bcd[11:8]), .o_nib_c(w_bcd_adj[11:8]));

  // Next-state and datapath strobes; a pending strobe restarts straight from COMMIT.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_shift     = 1'b0;
    w_commit    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (frame_start || r_pending) begin
          w_capture   = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == CNT_W'(W - 1)) begin
          w_state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        w_commit = 1'b1;
        if (r_pending) begin
          w_capture   = 1'b1;
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_bin        <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_pending    <= 1'b0;
      huns         <= 4'd0;
      tens         <= 4'd0;
      ones         <= 4'd0;
      digits_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      busy      <= (w_state_nxt != IDLE);
      done      <= w_commit;
      // Strobes seen mid-conversion merge into one pending restart.
      r_pending <= (frame_start && (r_state != IDLE)) || (r_pending && !w_capture);

      if (w_capture) begin
        r_bin <= w_score_sat;
        r_bcd <= '0;
        r_cnt <= '0;
      end else if (w_shift) begin
        {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
        r_cnt          <= r_cnt + CNT_W'(1);
      end

      if (w_commit) begin
        huns         <= r_bcd[11:8];
        tens         <= r_bcd[7:4];
        ones         <= r_bcd[3:0];
        digits_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_score_bcd_sequencer.sv
// Directed bench for score_bcd_sequencer: latency, clamping, pending restarts,
// mid-conversion reset and a full score sweep against a decimal reference.
module tb_score_bcd_sequencer;

  logic       clk;
  logic       reset_n;
  logic [9:0] score;
  logic       frame_start;
  logic [3:0] huns;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       digits_valid;
  logic       busy;
  logic       done;

  int n_checks;
  int n_fail;

  score_bcd_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .score        (score),
    .frame_start  (frame_start),
    .huns         (huns),
    .tens         (tens),
    .ones         (ones),
    .digits_valid (digits_valid),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int digits();
    return int'({huns, tens, ones});
  endfunction

  function automatic int ref_bcd(input int s);
    int v;
    v = (s > 999) ? 999 : s;
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  // Pulse frame_start with the given score, then wait (bounded) for done.
  task automatic run_conv(input int s, output int lat);
    score       = 10'(s);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done && lat < 30);
  endtask

  initial begin
    int lat;
    int bad_pre;
    int bad_sweep;
    n_checks    = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    score       = '0;
    frame_start = 1'b0;
    repeat (2) tick();

    check("reset_digits", digits(), 'h000);
    check("reset_valid", int'(digits_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    reset_n = 1'b1;
    tick();

    // Score 0: exact 11-cycle latency, busy throughout, one done pulse.
    score       = 10'd0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("zero_busy_e0", int'(busy), 1);
    bad_pre = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (done || !busy || digits_valid) bad_pre++;
    end
    check("zero_quiet_during_shift", bad_pre, 0);
    tick();
    check("zero_digits", digits(), 'h000);
    check("zero_valid", int'(digits_valid), 1);
    check("zero_done", int'(done), 1);
    check("zero_busy_after", int'(busy), 0);
    tick();
    check("zero_done_one_cycle", int'(done), 0);

    // Score 123: outputs hold until the commit edge.
    score       = 10'd123;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    bad_pre = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (digits() != 'h000) bad_pre++;
    end
    check("s123_hold_old", bad_pre, 0);
    tick();
    check("s123_digits", digits(), 'h123);
    check("s123_done", int'(done), 1);

    // Clamp boundaries.
    run_conv(1023, lat);
    check("s1023_latency", lat, 11);
    check("s1023_digits", digits(), 'h999);
    run_conv(999, lat);
    check("s999_digits", digits(), 'h999);
    run_conv(1000, lat);
    check("s1000_digits", digits(), 'h999);
    run_conv(998, lat);
    check("s998_digits", digits(), 'h998);

    // Score change mid-shift is ignored; strobe at cycle 5 chains a second run.
    score       = 10'd45;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      if (c == 3) score = 10'd678;
      if (c == 5) frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      if (c == 11) begin
        check("chain_first_digits", digits(), 'h045);
        check("chain_first_done", int'(done), 1);
        check("chain_busy_kept", int'(busy), 1);
      end
      if (c == 21) check("chain_hold_045", digits(), 'h045);
      if (c == 22) begin
        check("chain_second_digits", digits(), 'h678);
        check("chain_second_done", int'(done), 1);
      end
    end
    tick();
    check("chain_idle_after", int'(busy), 0);

    // Two strobes back-to-back from IDLE: second becomes pending.
    score       = 10'd7;
    frame_start = 1'b1;
    tick();
    score = 10'd300;
    tick();
    frame_start = 1'b0;
    for (int c = 2; c <= 22; c++) begin
      tick();
      if (c == 11) check("b2b_first_digits", digits(), 'h007);
      if (c == 22) check("b2b_second_digits", digits(), 'h300);
    end
    tick();

    // Reset mid-conversion aborts with no later commit.
    score       = 10'd250;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (5) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_digits", digits(), 'h000);
    check("rst_mid_valid", int'(digits_valid), 0);
    check("rst_mid_busy", int'(busy), 0);
    tick();
    reset_n = 1'b1;
    bad_pre = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done || busy || digits_valid || digits() != 'h000) bad_pre++;
    end
    check("rst_no_commit_after", bad_pre, 0);

    // Full sweep against the decimal reference.
    bad_sweep = 0;
    for (int s = 0; s < 1024; s++) begin
      run_conv(s, lat);
      if (lat != 11 || digits() != ref_bcd(s)) begin
        bad_sweep++;
        if (bad_sweep <= 4)
          $display("sweep score %0d: digits 0x%0h latency %0d", s, digits(), lat);
      end
    end
    check("sweep_errors", bad_sweep, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
